// File: rtl/bresenham_ctrl_if.sv
// Ray request / traced-cell handshake bundle for bresenham_ctrl.
interface bresenham_ctrl_if #(
    parameter int COORD_W = 16
);
    logic               ray_valid;
    logic               ray_ready;
    logic [COORD_W-1:0] ray_major;
    logic [COORD_W-1:0] ray_minor;
    logic               ray_flip_y;
    logic               ray_flip_x;
    logic               ray_flip_identity;
    logic [COORD_W-1:0] ray_origin_x;
    logic [COORD_W-1:0] ray_origin_y;
    logic               cell_valid;
    logic               cell_ready;
    logic [COORD_W-1:0] cell_x;
    logic [COORD_W-1:0] cell_y;
    logic               cell_last;

    modport master (
        output ray_valid, ray_major, ray_minor, ray_flip_y, ray_flip_x,
               ray_flip_identity, ray_origin_x, ray_origin_y, cell_ready,
        input  ray_ready, cell_valid, cell_x, cell_y, cell_last
    );

    modport slave (
        input  ray_valid, ray_major, ray_minor, ray_flip_y, ray_flip_x,
               ray_flip_identity, ray_origin_x, ray_origin_y, cell_ready,
        output ray_ready, cell_valid, cell_x, cell_y, cell_last
    );
endinterface

// File: rtl/bresenham_ctrl.sv
// Bresenham ray tracer: walks a first-octant ray and maps each cell back to its octant.
// Optional BRESENHAM_CTRL_ABORT_EN adds an abort input that drops the ray in flight.
//
// state | meaning
// IDLE  | waiting for a ray, ray_ready=1
// TRACE | emitting cells, cell_valid=1
module bresenham_ctrl #(
    parameter int COORD_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BRESENHAM_CTRL_ABORT_EN
    input  logic             abort,
`endif
    bresenham_ctrl_if.slave  bus,
    output logic             busy
);
    localparam int EW = COORD_W + 2;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [COORD_W-1:0]    u_q, u_d, v_q, v_d;
    logic signed [EW-1:0]  e_q, e_d;
    logic [COORD_W-1:0]    major_q, major_d, minor_q, minor_d;
    logic [COORD_W-1:0]    org_x_q, org_x_d, org_y_q, org_y_d;
    logic                  flip_x_q, flip_x_d, flip_y_q, flip_y_d, flip_id_q, flip_id_d;

    logic                  abort_w;
    logic                  last_w;
    logic signed [EW-1:0]  min_ext, maj_ext, rmin_ext, rmaj_ext, diff_w;
    logic [COORD_W-1:0]    a_w, b_w, dx_w, dy_w;

`ifdef BRESENHAM_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Zero-extended into the wider signed error domain so 2*minor cannot overflow.
    assign min_ext  = signed'({2'b00, minor_q});
    assign maj_ext  = signed'({2'b00, major_q});
    assign rmin_ext = signed'({2'b00, bus.ray_minor});
    assign rmaj_ext = signed'({2'b00, bus.ray_major});
    assign diff_w   = min_ext - maj_ext;
    assign last_w   = (state_q == ST_TRACE) && (u_q == major_q);

    always_comb begin
        state_d   = state_q;
        u_d       = u_q;
        v_d       = v_q;
        e_d       = e_q;
        major_d   = major_q;
        minor_d   = minor_q;
        org_x_d   = org_x_q;
        org_y_d   = org_y_q;
        flip_x_d  = flip_x_q;
        flip_y_d  = flip_y_q;
        flip_id_d = flip_id_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ray_valid) begin
                    state_d   = ST_TRACE;
                    u_d       = '0;
                    v_d       = '0;
                    e_d       = rmin_ext + rmin_ext - rmaj_ext;
                    major_d   = bus.ray_major;
                    minor_d   = bus.ray_minor;
                    org_x_d   = bus.ray_origin_x;
                    org_y_d   = bus.ray_origin_y;
                    flip_x_d  = bus.ray_flip_x;
                    flip_y_d  = bus.ray_flip_y;
                    flip_id_d = bus.ray_flip_identity;
                end
            end
            ST_TRACE: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                end else if (bus.cell_ready) begin
                    if (last_w) begin
                        state_d = ST_IDLE;
                    end else begin
                        u_d = u_q + 1'b1;
                        if (!e_q[EW-1] && (e_q != '0)) begin
                            v_d = v_q + 1'b1;
                            e_d = e_q + diff_w + diff_w;
                        end else begin
                            e_d = e_q + min_ext + min_ext;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            u_q       <= '0;
            v_q       <= '0;
            e_q       <= '0;
            major_q   <= '0;
            minor_q   <= '0;
            org_x_q   <= '0;
            org_y_q   <= '0;
            flip_x_q  <= 1'b0;
            flip_y_q  <= 1'b0;
            flip_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            u_q       <= u_d;
            v_q       <= v_d;
            e_q       <= e_d;
            major_q   <= major_d;
            minor_q   <= minor_d;
            org_x_q   <= org_x_d;
            org_y_q   <= org_y_d;
            flip_x_q  <= flip_x_d;
            flip_y_q  <= flip_y_d;
            flip_id_q <= flip_id_d;
        end
    end

    // Octant mapping: swap first, then negate each axis independently.
    always_comb begin
        a_w  = flip_id_q ? v_q : u_q;
        b_w  = flip_id_q ? u_q : v_q;
        dx_w = flip_x_q ? ('0 - a_w) : a_w;
        dy_w = flip_y_q ? ('0 - b_w) : b_w;
    end

    assign bus.cell_x     = org_x_q + dx_w;
    assign bus.cell_y     = org_y_q + dy_w;
    assign bus.cell_last  = last_w;
    assign bus.cell_valid = (state_q == ST_TRACE);
    assign bus.ray_ready  = (state_q == ST_IDLE);
    assign busy           = (state_q == ST_TRACE);
endmodule
